// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, the canonical NOP and the fetch state encoding.
package core_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_START   = 2'd0,
        FETCH_RUN     = 2'd1,
        FETCH_HALTED  = 2'd2
    } fetch_state_e;

endpackage : core_pkg

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program-memory port, pipeline control inputs and the IF/ID outputs.
// With FETCH_MISALIGN_TRAP_EN defined the bus also carries the misaligned flag.
interface fetch_unit_if;
    import core_pkg::*;

    logic [XLEN-1:0] mem_address;
    logic [ILEN-1:0] mem_value;
    logic            stall;
    logic            flush;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] if_id_pc;
    logic [ILEN-1:0] if_id_instr;
    logic            if_id_valid;
    logic            halted;
    logic [31:0]     fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misaligned;
`endif

    // Fetch-unit side
    modport master (
        output mem_address,
        input  mem_value,
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_target,
        output if_id_pc,
        output if_id_instr,
        output if_id_valid,
        output halted,
`ifdef FETCH_MISALIGN_TRAP_EN
        output misaligned,
`endif
        output fetch_count
    );

    // Memory / pipeline side
    modport slave (
        input  mem_address,
        output mem_value,
        output stall,
        output flush,
        output redirect,
        output redirect_target,
        input  if_id_pc,
        input  if_id_instr,
        input  if_id_valid,
        input  halted,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  misaligned,
`endif
        input  fetch_count
    );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, squash to a NOP bubble,
// invalidate while keeping the contents, or hold.
module if_id_reg
    import core_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic            i_inval,
    input  logic [XLEN-1:0] i_pc,
    input  logic [ILEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic            r_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : if_id_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives program memory and fills IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets instead of aligning them.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     MEM_WORDS = 128
)(
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS) * XLEN'(4);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    localparam logic [1:0] S_START  = 2'(FETCH_START);
    localparam logic [1:0] S_RUN    = 2'(FETCH_RUN);
    localparam logic [1:0] S_HALTED = 2'(FETCH_HALTED);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_halted;
    logic [31:0]     r_count;

    logic [1:0]      w_state_next;
    logic [XLEN-1:0] w_pc_next;
    logic            w_halted_next;
    logic [31:0]     w_count_next;
    logic            w_load;
    logic            w_clear;
    logic            w_inval;
    logic            w_in_range;
    logic            w_target_bad;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_misaligned;
    logic            w_misaligned_next;

    assign w_target     = bus.redirect_target;
    assign w_target_bad = |bus.redirect_target[1:0];
`else
    assign w_target     = bus.redirect_target & ~XLEN'(3);
    assign w_target_bad = 1'b0;
`endif

    assign w_in_range = (r_pc < MEM_BYTES);

    // Next-state and control decode; redirect outranks every other request in any state
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_halted_next = r_halted;
        w_count_next  = r_count;
        w_load        = 1'b0;
        w_clear       = 1'b0;
        w_inval       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misaligned_next = r_misaligned;
`endif
        if (bus.redirect) begin
            w_clear = 1'b1;
            if (w_target_bad) begin
                w_state_next  = S_HALTED;
                w_halted_next = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                w_misaligned_next = 1'b1;
`endif
            end else begin
                w_state_next  = S_RUN;
                w_pc_next     = w_target;
                w_halted_next = 1'b0;
            end
        end else begin
            case (r_state)
                S_START: w_state_next = S_RUN;
                S_RUN: begin
                    if (bus.flush) begin
                        w_clear = 1'b1;
                        if (!bus.stall) begin
                            w_pc_next = r_pc + PC_STEP;
                        end
                    end else if (bus.stall) begin
                        w_pc_next = r_pc;
                    end else if (!w_in_range) begin
                        w_state_next  = S_HALTED;
                        w_halted_next = 1'b1;
                        w_inval       = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_pc_next    = r_pc + PC_STEP;
                        w_count_next = r_count + 32'd1;
                    end
                end
                S_HALTED: w_state_next = S_HALTED;
                default:  w_state_next = S_START;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_START;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_halted <= w_halted_next;
            r_count  <= w_count_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap flag; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misaligned_next;
        end
    end

    assign bus.misaligned = r_misaligned;
`endif

    if_id_reg u_if_id_reg (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_inval (w_inval),
        .i_pc    (r_pc),
        .i_instr (bus.mem_value),
        .o_pc    (bus.if_id_pc),
        .o_instr (bus.if_id_instr),
        .o_valid (bus.if_id_valid)
    );

    assign bus.mem_address = r_pc;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_count;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus, a rule-level reference model
// compared every cycle, and hand-computed literal checkpoints.
module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(64'h0), .MEM_WORDS(128)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_value = (bus.mem_address < 64'd512) ? mem[bus.mem_address[8:2]] : 32'hDEAD_BEEF;

    // Reference model state
    logic [63:0] m_pc    = 64'h0;
    logic [63:0] m_ipc   = 64'h0;
    logic [31:0] m_instr = 32'h13;
    logic [31:0] m_cnt   = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_halt  = 1'b0;
    logic        m_bub   = 1'b1;
    logic        m_mis   = 1'b0;
    logic        m_live  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the per-cycle rules in priority order
    always @(posedge clock) begin
        if (reset) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h13; m_cnt = 0;
            m_valid = 0; m_halt = 0; m_bub = 1; m_mis = 0; m_live = 1;
        end else if (bus.redirect) begin
            m_valid = 0; m_instr = 32'h13; m_bub = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_target[1:0] != 2'b00) begin
                m_mis = 1; m_halt = 1;
            end else begin
                m_pc = bus.redirect_target; m_halt = 0;
            end
`else
            m_pc = {bus.redirect_target[63:2], 2'b00}; m_halt = 0;
`endif
        end else if (m_bub) begin
            m_bub = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (bus.flush) begin
            m_valid = 0; m_instr = 32'h13;
            if (!bus.stall) m_pc = m_pc + 64'd4;
        end else if (bus.stall) begin
            m_cnt = m_cnt;
        end else if (m_pc >= 64'd512) begin
            m_halt = 1; m_valid = 0;
        end else begin
            m_ipc = m_pc; m_instr = mem[m_pc[8:2]]; m_valid = 1;
            m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clock) begin
        if (m_live) begin
            chk("mem_address", bus.mem_address, m_pc);
            chk("if_id_pc", bus.if_id_pc, m_ipc);
            chk("if_id_instr", 64'(bus.if_id_instr), 64'(m_instr));
            chk("if_id_valid", 64'(bus.if_id_valid), 64'(m_valid));
            chk("halted", 64'(bus.halted), 64'(m_halt));
            chk("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("misaligned", 64'(bus.misaligned), 64'(m_mis));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic st, input logic fl, input logic rd, input logic [63:0] tgt);
        bus.stall = st; bus.flush = fl; bus.redirect = rd; bus.redirect_target = tgt;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
        drive(0, 0, 0, 64'h0);

        // Reset values
        step(2);
        chk("rst_addr", bus.mem_address, 64'h0);
        chk("rst_valid", 64'(bus.if_id_valid), 64'h0);
        chk("rst_instr", 64'(bus.if_id_instr), 64'h13);
        chk("rst_count", 64'(bus.fetch_count), 64'h0);
        chk("rst_halted", 64'(bus.halted), 64'h0);
        reset = 1'b0;

        // START bubble then sequential fetch
        step(1);
        chk("bubble_valid", 64'(bus.if_id_valid), 64'h0);
        step(1);
        chk("f0_pc", bus.if_id_pc, 64'h0);
        chk("f0_instr", 64'(bus.if_id_instr), 64'h1000_0000);
        step(1);
        chk("f1_pc", bus.if_id_pc, 64'h4);

        // Stall three cycles at pc=8
        drive(1, 0, 0, 64'h0);
        step(3);
        chk("stall_addr", bus.mem_address, 64'h8);
        chk("stall_ipc", bus.if_id_pc, 64'h4);
        chk("stall_cnt", 64'(bus.fetch_count), 64'd2);
        drive(0, 0, 0, 64'h0);
        step(1);
        chk("unstall_pc", bus.if_id_pc, 64'h8);
        chk("unstall_instr", 64'(bus.if_id_instr), 64'h1000_0002);
        step(1);
        chk("f3_pc", bus.if_id_pc, 64'hC);
        chk("f3_cnt", 64'(bus.fetch_count), 64'd4);

        // Redirect together with stall at pc=0x10
        drive(1, 0, 1, 64'h40);
        step(1);
        chk("redir_valid", 64'(bus.if_id_valid), 64'h0);
        chk("redir_addr", bus.mem_address, 64'h40);
        drive(0, 0, 0, 64'h0);
        step(1);
        chk("redir_ipc", bus.if_id_pc, 64'h40);
        chk("redir_instr", 64'(bus.if_id_instr), 64'h1000_0010);

        // Flush, then flush with stall
        drive(0, 1, 0, 64'h0);
        step(1);
        chk("flush_instr", 64'(bus.if_id_instr), 64'h13);
        chk("flush_addr", bus.mem_address, 64'h48);
        drive(1, 1, 0, 64'h0);
        step(1);
        chk("flush_stall_addr", bus.mem_address, 64'h48);

        // Misaligned redirect target
        drive(0, 0, 1, 64'h42);
        step(1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", 64'(bus.misaligned), 64'h1);
        chk("mis_halted", 64'(bus.halted), 64'h1);
        chk("mis_addr", bus.mem_address, 64'h48);
`else
        chk("mis_addr", bus.mem_address, 64'h40);
`endif

        // Run off the end of program memory
        drive(0, 0, 1, 64'h1F0);
        step(1);
        drive(0, 0, 0, 64'h0);
        for (int i = 0; i < 12 && !bus.halted; i++) step(1);
        chk("end_halted", 64'(bus.halted), 64'h1);
        chk("end_addr", bus.mem_address, 64'h200);
        chk("end_valid", 64'(bus.if_id_valid), 64'h0);
        chk("end_ipc", bus.if_id_pc, 64'h1FC);
        drive(1, 1, 0, 64'h0);
        step(2);
        drive(0, 0, 1, 64'h20);
        step(1);
        chk("resume_halted", 64'(bus.halted), 64'h0);
        chk("resume_addr", bus.mem_address, 64'h20);
        drive(0, 0, 0, 64'h0);
        step(1);
        chk("resume_ipc", bus.if_id_pc, 64'h20);
        step(3);
        chk("pre_rst_addr", bus.mem_address, 64'h30);
        chk("pre_rst_valid", 64'(bus.if_id_valid), 64'h1);

        // Mid-run reset
        reset = 1'b1;
        step(1);
        chk("mrst_addr", bus.mem_address, 64'h0);
        chk("mrst_valid", 64'(bus.if_id_valid), 64'h0);
        chk("mrst_cnt", 64'(bus.fetch_count), 64'h0);
        reset = 1'b0;
        step(1);
        chk("mrst_bubble", 64'(bus.if_id_valid), 64'h0);
        step(1);
        chk("mrst_f0", bus.if_id_pc, 64'h0);
        chk("mrst_f0_valid", 64'(bus.if_id_valid), 64'h1);

        // Redirect to the top of the address space halts on the range check
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        chk("top_addr", bus.mem_address, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 0, 0, 64'h0);
        step(1);
        chk("top_halted", 64'(bus.halted), 64'h1);

        // Redirect during the START bubble
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drive(0, 0, 1, 64'h80);
        step(1);
        chk("start_redir_addr", bus.mem_address, 64'h80);
        chk("start_redir_valid", 64'(bus.if_id_valid), 64'h0);
        drive(0, 0, 0, 64'h0);
        step(1);
        chk("start_redir_ipc", bus.if_id_pc, 64'h80);
        chk("start_redir_instr", 64'(bus.if_id_instr), 64'h1000_0020);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
